// File: rtl/wr_pkt_pkg.sv
// wr_pkt_pkg: shared definitions for the write packet generator.
//   - one-hot FSM state encoding
//   - LFSR polynomial / seed for the optional pseudo-random data pattern
//     (used only when WR_PKT_GEN_LFSR_EN is defined)
//   - cmd bus field offsets: cmd = {len, addr}, addr in the low bits
package wr_pkt_pkg;

  typedef enum logic [4:0] {
    StIdle = 5'b00001,
    StCmd  = 5'b00010,
    StData = 5'b00100,
    StGap  = 5'b01000,
    StEnd  = 5'b10000
  } state_e;

  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting left.
  localparam logic [31:0] LfsrPoly = 32'h0040_0007;
  localparam logic [31:0] LfsrSeed = 32'h0000_0001;

  // Address field starts at bit 0; length field sits directly above it.
  localparam int unsigned CmdAddrLsb = 0;

  function automatic int unsigned cmd_len_lsb(input int unsigned addr_w);
    return CmdAddrLsb + addr_w;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? LfsrPoly : 32'h0);
  endfunction

endpackage

// File: rtl/wr_pkt_pattern.sv
// wr_pkt_pattern: write data pattern generator, advances once per accepted beat.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - beat accepted (wr_valid & wr_ready)
//   data      - current pattern word (DATA_W bits)
// Build option: WR_PKT_GEN_LFSR_EN selects a 32-bit Galois LFSR replicated to
// DATA_W; otherwise data is a free-running incrementing counter.
module wr_pkt_pattern
  import wr_pkt_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [DATA_W-1:0] data
);

`ifdef WR_PKT_GEN_LFSR_EN
  localparam int unsigned Reps = (DATA_W + 31) / 32;

  logic [31:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LfsrSeed;
    end else if (en) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign data = DATA_W'({Reps{lfsr_q}});
`else
  logic [DATA_W-1:0] cnt_q;

  // Never cleared between packets or runs, only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + DATA_W'(1);
    end
  end

  assign data = cnt_q;
`endif

endmodule

// File: rtl/wr_pkt_gen.sv
// wr_pkt_gen: generates a run of write packets, each a {len, addr} command
// followed by BURST_LEN data beats, with optional idle gap between packets.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   trig                - start a run (only honoured when idle)
//   stop                - finish the current packet, then end the run
//   pkt_num             - packets per run, 0 = continuous until stop
//   cmd/cmd_valid/cmd_ready       - command channel, cmd = {len, addr}
//   wr_data/wr_valid/wr_ready/wr_last - data channel
//   busy                - high whenever not idle
//   done                - one-cycle pulse at end of run
//   pkt_cnt             - packets completed in the current run
// Build option: WR_PKT_GEN_LFSR_EN switches the data pattern to an LFSR.
module wr_pkt_gen
  import wr_pkt_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 13,
  parameter int unsigned BURST_LEN = 1024,
  parameter int unsigned ADDR_STEP = 8192,
  parameter int unsigned ADDR_BASE = 0,
  parameter int unsigned GAP_CYC   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trig,
  input  logic                    stop,
  input  logic [15:0]             pkt_num,
  output logic [LEN_W+ADDR_W-1:0] cmd,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic                    wr_last,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             pkt_cnt
);

  localparam logic [LEN_W-1:0]  BurstLen = LEN_W'(BURST_LEN);
  localparam logic [LEN_W-1:0]  BeatLast = LEN_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] AddrBase = ADDR_W'(ADDR_BASE);
  localparam logic [31:0]       GapLast  = 32'(GAP_CYC - 1);
  localparam int unsigned       LenLsb   = cmd_len_lsb(ADDR_W);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  beat_q;
  logic [31:0]       gap_q;
  logic [15:0]       pkt_cnt_q;
  logic [15:0]       pkt_num_q;
  logic              stop_q;    // stop seen since the current command was entered
  logic              last_pkt;

  assign last_pkt = (pkt_num_q != 16'd0) && (pkt_cnt_q + 16'd1 == pkt_num_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= AddrBase;
      beat_q    <= '0;
      gap_q     <= '0;
      pkt_cnt_q <= '0;
      pkt_num_q <= '0;
      stop_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trig) begin
            state_q   <= StCmd;
            pkt_num_q <= pkt_num;
            pkt_cnt_q <= '0;
            stop_q    <= 1'b0;
          end
        end
        StCmd: begin
          if (stop) stop_q <= 1'b1;
          if (cmd_ready) begin
            state_q <= StData;
            addr_q  <= addr_q + AddrStep;
            beat_q  <= '0;
          end
        end
        StData: begin
          if (stop) stop_q <= 1'b1;
          if (wr_ready) begin
            if (beat_q == BeatLast) begin
              pkt_cnt_q <= pkt_cnt_q + 16'd1;
              // A stop arriving with the last beat still ends the run.
              if (stop_q || stop || last_pkt) begin
                state_q <= StEnd;
              end else if (GAP_CYC != 0) begin
                state_q <= StGap;
                gap_q   <= '0;
              end else begin
                state_q <= StCmd;
                stop_q  <= 1'b0;
              end
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        StGap: begin
          if (stop) begin
            state_q <= StEnd;
          end else if (gap_q == GapLast) begin
            state_q <= StCmd;
            stop_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 32'd1;
          end
        end
        StEnd: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs decode straight from state flops: no path from the ready inputs.
  assign cmd_valid = (state_q == StCmd);
  assign wr_valid  = (state_q == StData);
  assign wr_last   = wr_valid && (beat_q == BeatLast);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StEnd);
  assign pkt_cnt   = pkt_cnt_q;

  assign cmd[CmdAddrLsb +: ADDR_W] = addr_q;
  assign cmd[LenLsb +: LEN_W]      = BurstLen;

  wr_pkt_pattern #(
    .DATA_W(DATA_W)
  ) u_pattern (
    .clk (clk),
    .rst (rst),
    .en  (wr_valid & wr_ready),
    .data(wr_data)
  );

endmodule

// File: tb/tb_wr_pkt_gen.sv
module tb_wr_pkt_gen;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 13;
  localparam int unsigned CW     = LEN_W + ADDR_W;

  logic clk = 1'b0, rst = 1'b1, trig = 1'b0, stop = 1'b0;
  logic cmd_ready = 1'b0, wr_ready = 1'b0, sel = 1'b0;
  logic [15:0] pkt_num = '0;
  logic trig_a, trig_b;

  logic [CW-1:0] cmd_a, cmd_b, o_cmd;
  logic [DATA_W-1:0] wr_data_a, wr_data_b, o_wr_data;
  logic [15:0] pkt_cnt_a, pkt_cnt_b, o_pkt_cnt;
  logic cmd_valid_a, wr_valid_a, wr_last_a, busy_a, done_a;
  logic cmd_valid_b, wr_valid_b, wr_last_b, busy_b, done_b;
  logic o_cmd_valid, o_wr_valid, o_wr_last, o_busy, o_done;

  always #5 clk = ~clk;

  // Instance A: defaults. Instance B: short bursts, gap, base near the top.
  assign trig_a = trig & ~sel;
  assign trig_b = trig & sel;

  wr_pkt_gen u_dut_a (
    .clk(clk), .rst(rst), .trig(trig_a), .stop(stop), .pkt_num(pkt_num),
    .cmd(cmd_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready),
    .wr_data(wr_data_a), .wr_valid(wr_valid_a), .wr_ready(wr_ready), .wr_last(wr_last_a),
    .busy(busy_a), .done(done_a), .pkt_cnt(pkt_cnt_a)
  );

  wr_pkt_gen #(
    .BURST_LEN(8), .GAP_CYC(4), .ADDR_BASE(32'hFFFF_E000)
  ) u_dut_b (
    .clk(clk), .rst(rst), .trig(trig_b), .stop(stop), .pkt_num(pkt_num),
    .cmd(cmd_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready),
    .wr_data(wr_data_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready), .wr_last(wr_last_b),
    .busy(busy_b), .done(done_b), .pkt_cnt(pkt_cnt_b)
  );

  assign o_cmd       = sel ? cmd_b : cmd_a;
  assign o_cmd_valid = sel ? cmd_valid_b : cmd_valid_a;
  assign o_wr_data   = sel ? wr_data_b : wr_data_a;
  assign o_wr_valid  = sel ? wr_valid_b : wr_valid_a;
  assign o_wr_last   = sel ? wr_last_b : wr_last_a;
  assign o_busy      = sel ? busy_b : busy_a;
  assign o_done      = sel ? done_b : done_a;
  assign o_pkt_cnt   = sel ? pkt_cnt_b : pkt_cnt_a;

  int tests_run = 0, tests_failed = 0;

  // Reference model: next packet address and next data word per instance.
  logic [ADDR_W-1:0] m_addr [2];
  logic [DATA_W-1:0] m_data [2];

  // Observations from the last run.
  logic [ADDR_W-1:0] got_addr[$];
  logic [LEN_W-1:0]  got_len[$];
  logic [DATA_W-1:0] got_data[$];
  bit                got_last[$];
  int                gaps[$];
  int n_done, done_lat, stall_bad, done_cnt, extra, timeout, held_cnt;

  function automatic int bl(input bit s);
    return s ? 8 : 1024;
  endfunction

  function automatic void model_reset();
    m_addr[0] = '0;
    m_addr[1] = 32'hFFFF_E000;
    m_data[0] = '0;
    m_data[1] = '0;
  endfunction

  function automatic void model_advance(input bit s, input int npk);
    m_addr[s] = m_addr[s] + ADDR_W'(npk * 8192);
    m_data[s] = m_data[s] + DATA_W'(npk * bl(s));
  endfunction

  // Count addr/len entries that disagree with base + i*step, len = burst.
  function automatic int bad_addrs(input bit s);
    int bad = 0;
    for (int i = 0; i < got_addr.size(); i++)
      if (got_addr[i] !== m_addr[s] + ADDR_W'(i * 8192) || got_len[i] !== LEN_W'(bl(s))) bad++;
    return bad;
  endfunction

  // Count beats whose value is not the next sequential word or whose last flag is misplaced.
  function automatic int bad_beats(input bit s);
    int bad = 0;
    for (int k = 0; k < got_data.size(); k++) begin
      if (got_data[k] !== m_data[s] + DATA_W'(k)) bad++;
      if (got_last[k] !== ((k % bl(s)) == bl(s) - 1)) bad++;
    end
    return bad;
  endfunction

  // Start a run and record every handshake until done (or budget expiry).
  task automatic run(input logic [15:0] num, input int rdy_pct, input int stop_beat,
                     input int budget);
    int beat = 0, cyc = 0, t_last = -1, t_gap = -1;
    bit fin = 0, stalled = 0, stop_used = 0;
    logic [DATA_W-1:0] prev = '0;
    got_addr.delete(); got_len.delete(); got_data.delete(); got_last.delete(); gaps.delete();
    n_done = 0; done_lat = -1; stall_bad = 0; done_cnt = -1; extra = 0; timeout = 0;
    pkt_num = num;
    trig = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0;
    while (!fin && cyc < budget) begin
      if (stalled && (!o_wr_valid || o_wr_data !== prev)) stall_bad++;
      if (o_cmd_valid && t_gap >= 0) begin
        gaps.push_back(cyc - t_gap - 1);
        t_gap = -1;
      end
      if (o_done) begin
        n_done++;
        done_lat = cyc - t_last;
        done_cnt = int'(o_pkt_cnt);
        fin = 1;
      end
      stop = !stop_used && (beat == stop_beat);
      if (stop) stop_used = 1;
      trig = ($urandom_range(63) == 0);   // never idle here, must be ignored
      pkt_num = 16'($urandom);            // only sampled on an accepted trig
      cmd_ready = ($urandom_range(99) < rdy_pct);
      wr_ready = ($urandom_range(99) < rdy_pct);
      if (o_cmd_valid && cmd_ready) begin
        got_addr.push_back(o_cmd[ADDR_W-1:0]);
        got_len.push_back(o_cmd[ADDR_W +: LEN_W]);
      end
      if (o_wr_valid && wr_ready) begin
        got_data.push_back(o_wr_data);
        got_last.push_back(o_wr_last);
        beat++;
        if (o_wr_last) begin
          t_last = cyc;
          t_gap = cyc;
        end
      end
      stalled = o_wr_valid && !wr_ready;
      prev = o_wr_data;
      @(posedge clk); #1;
      cyc++;
    end
    trig = 1'b0; stop = 1'b0; cmd_ready = 1'b1; wr_ready = 1'b1;
    if (!fin) timeout = 1;
    for (int i = 0; i < 16; i++) begin
      if (o_cmd_valid || o_busy || o_wr_valid || o_done) extra++;
      @(posedge clk); #1;
    end
    held_cnt = int'(o_pkt_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    tests_run++;
    if (cmd_a !== {13'd1024, 32'h0}) begin
      tests_failed++; $display("FAIL reset_cmd_a: got %h want %h", cmd_a, {13'd1024, 32'h0});
    end
    tests_run++;
    if (cmd_b !== {13'd8, 32'hFFFF_E000}) begin
      tests_failed++; $display("FAIL reset_cmd_b: got %h want %h", cmd_b, {13'd8, 32'hFFFF_E000});
    end
    tests_run++;
    if ({cmd_valid_a, wr_valid_a, wr_last_a, busy_a, done_a, wr_data_a, pkt_cnt_a} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outs: got cv%b wv%b wl%b b%b d%b data%h cnt%0d want all 0",
               cmd_valid_a, wr_valid_a, wr_last_a, busy_a, done_a, wr_data_a, pkt_cnt_a);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    sel = 1'b0;
    run(16'd1, 100, -1, 4000);
    tests_run++;
    if (timeout != 0 || n_done != 1 || done_lat != 1) begin
      tests_failed++;
      $display("FAIL single_done: got timeout=%0d n_done=%0d lat=%0d want 0 1 1",
               timeout, n_done, done_lat);
    end
    tests_run++;
    if (got_addr.size() != 1 || bad_addrs(0) != 0) begin
      tests_failed++;
      $display("FAIL single_cmd: got %0d cmds bad=%0d want 1 cmd {1024,%h}",
               got_addr.size(), bad_addrs(0), m_addr[0]);
    end
    tests_run++;
    if (got_data.size() != 1024 || bad_beats(0) != 0) begin
      tests_failed++;
      $display("FAIL single_data: got %0d beats bad=%0d want 1024 from %0d",
               got_data.size(), bad_beats(0), m_data[0]);
    end
    tests_run++;
    if (done_cnt != 1 || held_cnt != 1 || extra != 0) begin
      tests_failed++;
      $display("FAIL single_cnt: got cnt=%0d held=%0d extra=%0d want 1 1 0",
               done_cnt, held_cnt, extra);
    end
    model_advance(0, 1);
  endtask

  task automatic test_wrap();
    sel = 1'b1;
    run(16'd2, 100, -1, 400);
    tests_run++;
    if (got_addr.size() != 2 || got_addr[0] !== 32'hFFFF_E000 || got_addr[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_addr: got n=%0d a0=%h a1=%h want FFFFE000 00000000",
               got_addr.size(), got_addr.size() > 0 ? got_addr[0] : 32'hx,
               got_addr.size() > 1 ? got_addr[1] : 32'hx);
    end
    tests_run++;
    if (timeout != 0 || done_cnt != 2 || bad_beats(1) != 0 || got_data.size() != 16) begin
      tests_failed++;
      $display("FAIL wrap_run: got timeout=%0d cnt=%0d bad=%0d beats=%0d want 0 2 0 16",
               timeout, done_cnt, bad_beats(1), got_data.size());
    end
    model_advance(1, 2);
  endtask

  task automatic test_gap();
    sel = 1'b1;
    run(16'd3, 100, -1, 400);
    tests_run++;
    if (gaps.size() != 2 || gaps[0] != 4 || gaps[1] != 4) begin
      tests_failed++;
      $display("FAIL gap_len: got n=%0d g0=%0d g1=%0d want 2 gaps of 4", gaps.size(),
               gaps.size() > 0 ? gaps[0] : -1, gaps.size() > 1 ? gaps[1] : -1);
    end
    tests_run++;
    if (got_addr.size() != 3 || bad_addrs(1) != 0) begin
      tests_failed++;
      $display("FAIL gap_addr: got %0d cmds bad=%0d want 3 from %h",
               got_addr.size(), bad_addrs(1), m_addr[1]);
    end
    tests_run++;
    if (done_cnt != 3 || done_lat != 1 || bad_beats(1) != 0 || got_data.size() != 24) begin
      tests_failed++;
      $display("FAIL gap_run: got cnt=%0d lat=%0d bad=%0d beats=%0d want 3 1 0 24",
               done_cnt, done_lat, bad_beats(1), got_data.size());
    end
    model_advance(1, 3);
    // Stop raised in the first gap cycle ends the run one cycle later.
    run(16'd0, 100, 8, 400);
    tests_run++;
    if (timeout != 0 || got_addr.size() != 1 || done_cnt != 1 || done_lat != 2) begin
      tests_failed++;
      $display("FAIL gap_stop: got timeout=%0d cmds=%0d cnt=%0d lat=%0d want 0 1 1 2",
               timeout, got_addr.size(), done_cnt, done_lat);
    end
    model_advance(1, 1);
  endtask

  task automatic test_stall();
    sel = 1'b0;
    run(16'd2, 50, -1, 12000);
    tests_run++;
    if (stall_bad != 0) begin
      tests_failed++; $display("FAIL stall_hold: got %0d changed stalls want 0", stall_bad);
    end
    tests_run++;
    if (timeout != 0 || got_data.size() != 2048 || bad_beats(0) != 0) begin
      tests_failed++;
      $display("FAIL stall_data: got timeout=%0d beats=%0d bad=%0d want 0 2048 0",
               timeout, got_data.size(), bad_beats(0));
    end
    tests_run++;
    if (bad_addrs(0) != 0 || got_addr.size() != 2 || done_cnt != 2) begin
      tests_failed++;
      $display("FAIL stall_cmd: got cmds=%0d bad=%0d cnt=%0d want 2 0 2",
               got_addr.size(), bad_addrs(0), done_cnt);
    end
    model_advance(0, 2);
  endtask

  task automatic test_stop();
    sel = 1'b0;
    for (int r = 0; r < 2; r++) begin
      // r=0: stop right as packet 2's command is offered; r=1: random point in packet 2.
      int sb = (r == 0) ? 1024 : 1024 + int'($urandom_range(1, 1023));
      run(16'd0, 80, sb, 8000);
      tests_run++;
      if (timeout != 0 || n_done != 1 || got_addr.size() != 2 || extra != 0) begin
        tests_failed++;
        $display("FAIL stop_cmds(%0d): got timeout=%0d done=%0d cmds=%0d extra=%0d want 0 1 2 0",
                 sb, timeout, n_done, got_addr.size(), extra);
      end
      tests_run++;
      if (got_data.size() != 2048 || bad_beats(0) != 0 || done_cnt != 2) begin
        tests_failed++;
        $display("FAIL stop_data(%0d): got beats=%0d bad=%0d cnt=%0d want 2048 0 2",
                 sb, got_data.size(), bad_beats(0), done_cnt);
      end
      model_advance(0, 2);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run(16'd2, 100, -1, 4000);
    tests_run++;
    if (gaps.size() != 1 || gaps[0] != 0) begin
      tests_failed++;
      $display("FAIL b2b_gap: got n=%0d g0=%0d want one gap of 0", gaps.size(),
               gaps.size() > 0 ? gaps[0] : -1);
    end
    tests_run++;
    if (done_cnt != 2 || bad_addrs(0) != 0 || bad_beats(0) != 0 || got_data.size() != 2048) begin
      tests_failed++;
      $display("FAIL b2b_run: got cnt=%0d badaddr=%0d baddata=%0d beats=%0d want 2 0 0 2048",
               done_cnt, bad_addrs(0), bad_beats(0), got_data.size());
    end
    model_advance(0, 2);
  endtask

  task automatic test_rst_mid();
    int n = 0, cyc = 0;
    sel = 1'b0;
    pkt_num = 16'd1;
    trig = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0; cmd_ready = 1'b1; wr_ready = 1'b1;
    while (n < 500 && cyc < 2000) begin
      if (o_wr_valid) n++;
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (n != 500 || {cmd_valid_a, wr_valid_a, wr_last_a, busy_a, done_a} !== 5'b0 ||
        wr_data_a !== '0 || pkt_cnt_a !== '0 || cmd_a !== {13'd1024, 32'h0}) begin
      tests_failed++;
      $display("FAIL rst_mid_outs: got n=%0d cv%b wv%b wl%b b%b d%b data=%h cnt=%0d cmd=%h",
               n, cmd_valid_a, wr_valid_a, wr_last_a, busy_a, done_a, wr_data_a, pkt_cnt_a,
               cmd_a);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    run(16'd1, 100, -1, 4000);
    tests_run++;
    if (got_addr.size() != 1 || got_addr[0] !== 32'h0 || got_data.size() != 1024 ||
        got_data[0] !== 64'h0 || bad_beats(0) != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_restart: got cmds=%0d beats=%0d bad=%0d want 1 at 0, 1024 from 0",
               got_addr.size(), got_data.size(), bad_beats(0));
    end
    model_advance(0, 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_gap();
    test_stall();
    test_stop();
    test_back_to_back();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
